// File: rtl/mips_dmem_responder_if.sv
// mips_dmem_responder_if: load/store request and response bus between the MEM stage and data memory
interface mips_dmem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: single-outstanding data memory with fixed wait states and byte-lane stores
module mips_dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic                 clock,
    input logic                 reset_n,
    mips_dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t          state, state_next;
    logic [3:0]      cnt;
    logic            lat_write;
    logic [AW+1:0]   lat_addr;
    logic [31:0]     lat_wdata;
    logic [3:0]      lat_be;
    logic            idle, accept, enter_resp, misaligned;
    logic            cur_write;
    logic [AW+1:0]   cur_addr;
    logic [31:0]     cur_wdata, word, merged;
    logic [3:0]      cur_be;
    logic [31:0]     mem [DEPTH];
    logic            unused_addr;
    assign idle          = state == S_IDLE;
    assign bus.req_ready = idle;
    assign bus.busy      = !idle;
    assign accept        = idle && bus.req_valid;
    assign unused_addr   = ^bus.req_addr[31:AW+2];
    // With no wait states the request is serviced on its accept edge, before the latches hold it.
    assign cur_write  = idle ? bus.req_write : lat_write;
    assign cur_addr   = idle ? bus.req_addr[AW+1:0] : lat_addr;
    assign cur_wdata  = idle ? bus.req_wdata : lat_wdata;
    assign cur_be     = idle ? bus.req_be : lat_be;
    assign misaligned = cur_addr[1:0] != 2'b00;
    assign word       = mem[cur_addr[AW+1:2]];
    assign enter_resp = state_next == S_RESP;
    always_comb begin
        state_next = state;
        if (idle && accept)
            state_next = WAIT_CYCLES > 0 ? S_WAIT : S_RESP;
        else if (state == S_WAIT && cnt == 4'd0)
            state_next = S_RESP;
        else if (state == S_RESP)
            state_next = S_IDLE;
    end
    always_comb begin
        merged = word;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = cur_be[i] ? cur_wdata[8*i +: 8] : word[8*i +: 8];
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            cnt            <= 4'd0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'd0;
        end else begin
            state          <= state_next;
            cnt            <= accept ? 4'(WAIT_CYCLES - 1) : (state == S_WAIT ? cnt - 4'd1 : cnt);
            bus.resp_valid <= enter_resp;
            if (enter_resp) begin
                bus.resp_err   <= misaligned;
                bus.resp_rdata <= (misaligned || cur_write) ? 32'd0 : word;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (accept) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr[AW+1:0];
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
        end
        if (reset_n && enter_resp && cur_write && !misaligned)
            mem[cur_addr[AW+1:2]] <= merged;
    end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder: randomized and directed checks of the data-memory responder against a word-array model
module tb_mips_dmem_responder;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;
    mips_dmem_responder_if bus ();
    mips_dmem_responder_if bus0 ();
    mips_dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    mips_dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] ref_mem [256];
    task automatic model(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         output logic [31:0] exp_rd, output logic exp_err);
        exp_err = a[1:0] != 2'b00;
        exp_rd  = 32'd0;
        if (!exp_err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
            end else
                exp_rd = ref_mem[a[9:2]];
        end
    endtask
    // Issues one request to the two-wait-state DUT; lat counts cycles from the accept cycle to resp_valid.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rd, output logic er, output int lat, output logic ok);
        int n;
        n = 0;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = wd; bus.req_be = be;
        while (!bus.req_ready && n < 20) begin @(posedge clock); #1; n++; end
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 40) begin @(posedge clock); #1; lat++; end
        ok = bus.resp_valid;
        rd = bus.resp_rdata;
        er = bus.resp_err;
        @(posedge clock); #1;
    endtask
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.req_ready); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); end
        n_tests++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got %b exp 0", bus.resp_err); end
        n_tests++; if (bus.resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_resp_rdata got %h exp 0", bus.resp_rdata); end
        n_tests++; if (bus0.req_ready !== 1'b1 || bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_w0 got ready=%b busy=%b exp 1/0", bus0.req_ready, bus0.busy); end
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask
    task automatic test_init();
        logic [31:0] rd, d;
        logic er, ok;
        int lat;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            ref_mem[i] = d;
            do_req(1'b1, 32'(i * 4), d, 4'hF, rd, er, lat, ok);
        end
    endtask
    task automatic test_basic();
        logic [31:0] rd, erd;
        logic er, eer, ok;
        int lat;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, ok); model(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_store_resp got %b exp 1", ok); end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL basic_store_latency got %0d exp 3", lat); end
        n_tests++; if (er !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL basic_store_resp got err=%b rdata=%h exp 0/0", er, rd); end
        do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat, ok); model(1'b0, 32'h10, 32'h0, 4'hF, erd, eer);
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL basic_load_latency got %0d exp 3", lat); end
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_load_rdata got %h exp deadbeef", rd); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL basic_load_err got %b exp 0", er); end
    endtask
    task automatic test_partial();
        logic [31:0] rd, erd;
        logic er, eer, ok;
        int lat;
        do_req(1'b1, 32'h10, 32'h00001234, 4'h3, rd, er, lat, ok); model(1'b1, 32'h10, 32'h00001234, 4'h3, erd, eer);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ok); model(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        n_tests++; if (rd !== 32'hDEAD1234) begin n_fail++; $display("FAIL partial_load got %h exp dead1234", rd); end
        do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat, ok); model(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, erd, eer);
        n_tests++; if (ok !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL zero_be_resp got ok=%b err=%b exp 1/0", ok, er); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ok); model(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        n_tests++; if (rd !== 32'hDEAD1234) begin n_fail++; $display("FAIL zero_be_load got %h exp dead1234", rd); end
    endtask
    task automatic test_wrap();
        logic [31:0] rd, erd;
        logic er, eer, ok;
        int lat;
        do_req(1'b1, 32'h400, 32'h55, 4'hF, rd, er, lat, ok); model(1'b1, 32'h400, 32'h55, 4'hF, erd, eer);
        do_req(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat, ok); model(1'b0, 32'h0, 32'h0, 4'hF, erd, eer);
        n_tests++; if (rd !== 32'h00000055) begin n_fail++; $display("FAIL wrap_load got %h exp 00000055", rd); end
    endtask
    task automatic test_misaligned();
        logic [31:0] rd, erd;
        logic er, eer, ok;
        int lat;
        do_req(1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat, ok); model(1'b0, 32'h13, 32'h0, 4'hF, erd, eer);
        n_tests++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL misaligned_load got err=%b rdata=%h exp 1/0", er, rd); end
        do_req(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, rd, er, lat, ok); model(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, erd, eer);
        n_tests++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL misaligned_store got err=%b rdata=%h exp 1/0", er, rd); end
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL misaligned_latency got %0d exp 3", lat); end
        do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat, ok); model(1'b0, 32'h10, 32'h0, 4'hF, erd, eer);
        n_tests++; if (rd !== 32'hDEAD1234 || er !== 1'b0) begin n_fail++; $display("FAIL misaligned_untouched got %h err=%b exp dead1234/0", rd, er); end
    endtask
    task automatic test_random();
        logic [31:0] rd, erd, a, wd;
        logic er, eer, ok, wr;
        logic [3:0] be;
        int lat;
        for (int k = 0; k < 150; k++) begin
            wr = 1'($urandom);
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            wd = $urandom;
            be = 4'($urandom);
            do_req(wr, a, wd, be, rd, er, lat, ok);
            model(wr, a, wd, be, erd, eer);
            n_tests++; if (rd !== erd || er !== eer) begin n_fail++; $display("FAIL random_%0d wr=%b addr=%h got rdata=%h err=%b exp %h/%b", k, wr, a, rd, er, erd, eer); end
            n_tests++; if (lat != 3) begin n_fail++; $display("FAIL random_latency_%0d got %0d exp 3", k, lat); end
        end
    endtask
    task automatic test_handshake();
        int last, last0, cnt, cnt0;
        last = -1; last0 = -1; cnt = 0; cnt0 = 0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_be = 4'hF;
        bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_be = 4'hF;
        for (int c = 0; c < 40; c++) begin
            bus.req_addr = $urandom;
            bus0.req_addr = $urandom;
            n_tests++; if (bus.busy && bus.req_ready) begin n_fail++; $display("FAIL hs_ready_while_busy cycle %0d got ready=1 exp 0", c); end
            n_tests++; if (bus0.busy && bus0.req_ready) begin n_fail++; $display("FAIL hs0_ready_while_busy cycle %0d got ready=1 exp 0", c); end
            if (bus.resp_valid) begin
                n_tests++; if (c != last + 3) begin n_fail++; $display("FAIL hs_resp_cycle got %0d exp %0d", c, last + 3); end
            end
            if (bus0.resp_valid) begin
                n_tests++; if (c != last0 + 1) begin n_fail++; $display("FAIL hs0_resp_cycle got %0d exp %0d", c, last0 + 1); end
            end
            if (bus.req_ready) begin
                if (last >= 0) begin n_tests++; if (c - last != 4) begin n_fail++; $display("FAIL hs_spacing got %0d exp 4", c - last); end end
                last = c; cnt++;
            end
            if (bus0.req_ready) begin
                if (last0 >= 0) begin n_tests++; if (c - last0 != 2) begin n_fail++; $display("FAIL hs0_spacing got %0d exp 2", c - last0); end end
                last0 = c; cnt0++;
            end
            @(posedge clock); #1;
        end
        bus.req_valid = 1'b0; bus0.req_valid = 1'b0;
        n_tests++; if (cnt != 10) begin n_fail++; $display("FAIL hs_accepts got %0d exp 10", cnt); end
        n_tests++; if (cnt0 != 20) begin n_fail++; $display("FAIL hs0_accepts got %0d exp 20", cnt0); end
        repeat (6) @(posedge clock);
        #1;
    endtask
    task automatic test_reset_midop();
        logic [31:0] rd, erd;
        logic er, eer, ok;
        int lat, seen;
        do_req(1'b1, 32'h20, 32'h11111111, 4'hF, rd, er, lat, ok); model(1'b1, 32'h20, 32'h11111111, 4'hF, erd, eer);
        for (int depth = 1; depth <= 2; depth++) begin
            bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'hAAAA5555; bus.req_be = 4'hF;
            @(posedge clock); #1;
            bus.req_valid = 1'b0;
            repeat (depth - 1) begin @(posedge clock); #1; end
            reset_n = 1'b0;
            @(posedge clock); #1;
            n_tests++; if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL midop_reset_%0d got busy=%b resp_valid=%b exp 0/0", depth, bus.busy, bus.resp_valid); end
            reset_n = 1'b1;
            seen = 0;
            repeat (6) begin @(posedge clock); #1; if (bus.resp_valid) seen++; end
            n_tests++; if (seen != 0) begin n_fail++; $display("FAIL midop_no_resp_%0d got %0d exp 0", depth, seen); end
            do_req(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, ok); model(1'b0, 32'h20, 32'h0, 4'hF, erd, eer);
            n_tests++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL midop_load_%0d got %h exp 11111111", depth, rd); end
        end
    endtask
    task automatic test_reset_resp();
        logic [31:0] rd, erd;
        logic er, eer, ok;
        int lat, n;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h24; bus.req_wdata = 32'h22222222; bus.req_be = 4'hF;
        model(1'b1, 32'h24, 32'h22222222, 4'hF, erd, eer);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 20) begin @(posedge clock); #1; n++; end
        n_tests++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL resp_reset_wait got resp_valid=%b exp 1", bus.resp_valid); end
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        do_req(1'b0, 32'h24, 32'h0, 4'hF, rd, er, lat, ok); model(1'b0, 32'h24, 32'h0, 4'hF, erd, eer);
        n_tests++; if (rd !== 32'h22222222) begin n_fail++; $display("FAIL resp_reset_load got %h exp 22222222", rd); end
    endtask
    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_be = 4'd0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = 32'd0; bus0.req_wdata = 32'd0; bus0.req_be = 4'd0;
        test_reset();
        test_init();
        test_basic();
        test_partial();
        test_wrap();
        test_misaligned();
        test_random();
        test_handshake();
        test_reset_midop();
        test_reset_resp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL timeout reached before completion");
        $fatal(1, "timeout");
    end
endmodule
